// File: rtl/gpio_cnt_multi_pkg.sv
// Shared types for the multi-channel GPIO counter.
// Channel modes and per-channel FSM states.
package gpio_cnt_multi_pkg;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_LEVEL,
    MODE_EDGE,
    MODE_PULSE
  } gpio_cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HOLD,
    ST_FIRE_P
  } gpio_cnt_state_e;

  function automatic logic mode_on(gpio_cnt_mode_e m);
    return m != MODE_OFF;
  endfunction

endpackage

// File: rtl/gpio_cnt_ch.sv
// One GPIO counter channel: synchroniser, edge detect,
// saturating counter, response FSM and pulse timer.
module gpio_cnt_ch
  import gpio_cnt_multi_pkg::*;
#(
  parameter int CntWidth   = 16,
  parameter int SyncStages = 2,
  parameter int PulseLen   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          mode,
  input  logic [CntWidth-1:0] thresh,
  input  logic                clear,
  input  logic                line,
  output logic                resp,
  output logic                done,
  output logic [CntWidth-1:0] cnt
);

  localparam int PW = $clog2(PulseLen + 1);

  logic [SyncStages-1:0] sync;
  logic                  s;
  logic                  s_q;
  logic                  rise;
  gpio_cnt_mode_e        mode_in;
  gpio_cnt_mode_e        mode_q;
  gpio_cnt_state_e       state;
  logic                  hit;
  logic                  wipe;
  logic                  step;
  logic                  bump;
  logic [CntWidth-1:0]   cnt_nxt;
  logic [PW-1:0]         pcnt;

  assign mode_in = gpio_cnt_mode_e'(mode);
  assign s       = sync[SyncStages-1];
  assign rise    = s & ~s_q;
  assign wipe    = clear | (mode_in != mode_q);
  assign bump    = step & ~(&cnt);
  assign cnt_nxt = cnt + CntWidth'(1);

  // Synchronise the DUT line, keep one delayed copy for edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync   <= '0;
      s_q    <= 1'b0;
      mode_q <= MODE_OFF;
    end else begin
      sync   <= SyncStages'({sync, line});
      s_q    <= s;
      mode_q <= mode_in;
    end
  end

  // Select what counts as an increment in the active mode
  always_comb begin
    step = 1'b0;
    unique case (mode_q)
      MODE_LEVEL:            step = s;
      MODE_EDGE, MODE_PULSE: step = rise;
      default:               step = 1'b0;
    endcase
  end

  // Channel FSM; a match is flagged on the increment and acted on next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hit   <= 1'b0;
      resp  <= 1'b0;
      done  <= 1'b0;
      pcnt  <= '0;
    end else begin
      done <= 1'b0;
      if (wipe) begin
        state <= mode_on(mode_in) ? ST_COUNT : ST_IDLE;
        cnt   <= '0;
        hit   <= 1'b0;
        resp  <= 1'b0;
        pcnt  <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            cnt  <= '0;
            resp <= 1'b0;
            if (mode_on(mode_q)) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (hit) begin
              hit  <= 1'b0;
              done <= 1'b1;
              resp <= 1'b1;
              if (mode_q == MODE_PULSE) begin
                state <= ST_FIRE_P;
                pcnt  <= PW'(PulseLen - 1);
              end else begin
                state <= ST_HOLD;
              end
            end else if (bump) begin
              cnt <= cnt_nxt;
              hit <= (cnt_nxt == thresh);
            end
          end
          ST_HOLD: begin
            resp <= 1'b1;
          end
          ST_FIRE_P: begin
            if (pcnt == '0) begin
              state <= ST_COUNT;
              resp  <= 1'b0;
              cnt   <= '0;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/gpio_cnt_multi.sv
// Multi-channel GPIO counter: NumCh independent channels
// with flattened configuration and status ports.
module gpio_cnt_multi
  import gpio_cnt_multi_pkg::*;
#(
  parameter int NumCh      = 4,
  parameter int CntWidth   = 16,
  parameter int SyncStages = 2,
  parameter int PulseLen   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [2*NumCh-1:0]        cfg_mode_i,
  input  logic [NumCh*CntWidth-1:0] cfg_max_i,
  input  logic [NumCh-1:0]          clear_i,
  input  logic [NumCh-1:0]          gpio_i,
  output logic [NumCh-1:0]          gpio_o,
  output logic [NumCh-1:0]          done_o,
  output logic [NumCh*CntWidth-1:0] cnt_o
);

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    gpio_cnt_ch #(
      .CntWidth  (CntWidth),
      .SyncStages(SyncStages),
      .PulseLen  (PulseLen)
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .mode  (cfg_mode_i[2*g +: 2]),
      .thresh(cfg_max_i[g*CntWidth +: CntWidth]),
      .clear (clear_i[g]),
      .line  (gpio_i[g]),
      .resp  (gpio_o[g]),
      .done  (done_o[g]),
      .cnt   (cnt_o[g*CntWidth +: CntWidth])
    );
  end

endmodule

// File: tb/tb_gpio_cnt_multi.sv
// Directed bench for gpio_cnt_multi: cycle table plus
// hand sequences for level, pulse, reset and saturation.
module tb_gpio_cnt_multi;
  import gpio_cnt_multi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_mode = '0;
  logic [63:0] a_max = '0;
  logic [3:0]  a_clr = '0;
  logic [3:0]  a_gin = '0;
  logic [3:0]  a_gout;
  logic [3:0]  a_done;
  logic [63:0] a_cnt;

  logic [3:0] b_mode = '0;
  logic [7:0] b_max = '0;
  logic [1:0] b_clr = '0;
  logic [1:0] b_gin = '0;
  logic [1:0] b_gout;
  logic [1:0] b_done;
  logic [7:0] b_cnt;

  gpio_cnt_multi #(
    .NumCh(4), .CntWidth(16), .SyncStages(2), .PulseLen(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_mode_i(a_mode), .cfg_max_i(a_max),
    .clear_i(a_clr), .gpio_i(a_gin),
    .gpio_o(a_gout), .done_o(a_done), .cnt_o(a_cnt)
  );

  gpio_cnt_multi #(
    .NumCh(2), .CntWidth(4), .SyncStages(2), .PulseLen(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_mode_i(b_mode), .cfg_max_i(b_max),
    .clear_i(b_clr), .gpio_i(b_gin),
    .gpio_o(b_gout), .done_o(b_done), .cnt_o(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    logic        g;
    logic [15:0] cnt;
    logic        go;
    logic        dn;
  } vec_t;

  vec_t tv[29];

  initial begin
    int dn, run, pulses, bad;
    logic [15:0] ec;

    // EDGE, max 3: 5 edges, hold, clear; then clear on the increment to max
    tv[0]  = '{2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[1]  = '{2'd2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    tv[2]  = '{2'd2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    tv[3]  = '{2'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tv[4]  = '{2'd2, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tv[5]  = '{2'd2, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tv[6]  = '{2'd2, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0};
    tv[7]  = '{2'd2, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tv[8]  = '{2'd2, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tv[9]  = '{2'd2, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
    tv[10] = '{2'd2, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1};
    tv[11] = '{2'd2, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    tv[12] = '{2'd2, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    tv[13] = '{2'd2, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    tv[14] = '{2'd2, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    tv[15] = '{2'd2, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    tv[16] = '{2'd2, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[17] = '{2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[18] = '{2'd2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    tv[19] = '{2'd2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    tv[20] = '{2'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tv[21] = '{2'd2, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tv[22] = '{2'd2, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tv[23] = '{2'd2, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0};
    tv[24] = '{2'd2, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tv[25] = '{2'd2, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tv[26] = '{2'd2, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[27] = '{2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[28] = '{2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};

    a_max[15:0] = 16'd3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", a_gout, 4'h0);
    chk("rst_cnt", a_cnt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_done", a_done, 4'h0);
    chk("post_rst_cnt", a_cnt, 64'h0);

    // Table-driven EDGE sequence on channel 0
    foreach (tv[i]) begin
      a_mode[1:0] = tv[i].mode;
      a_clr[0] = tv[i].clr;
      a_gin[0] = tv[i].g;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_cnt", i), a_cnt[15:0], tv[i].cnt);
      chk($sformatf("tv%0d_gpio", i), a_gout[0], tv[i].go);
      chk($sformatf("tv%0d_done", i), a_done[0], tv[i].dn);
    end
    a_clr[0] = 1'b0;

    // LEVEL, max 16, line held high on channel 1
    a_max[31:16] = 16'd16;
    a_mode[3:2] = MODE_LEVEL;
    a_gin[1] = 1'b1;
    dn = 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1;
      ec = (c < 3) ? 16'd0 : ((c - 2 > 16) ? 16'd16 : 16'(c - 2));
      if (a_done[1]) dn++;
      chk($sformatf("lvl_c%0d_cnt", c), a_cnt[31:16], ec);
      chk($sformatf("lvl_c%0d_done", c), a_done[1], c == 19);
      chk($sformatf("lvl_c%0d_gpio", c), a_gout[1], c >= 19);
    end
    chk("lvl_done_count", dn, 1);
    a_gin[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("lvl_sticky_gpio", a_gout[1], 1'b1);
    chk("lvl_frozen_cnt", a_cnt[31:16], 16'd16);

    // Mode change while holding acts as a clear
    a_mode[3:2] = MODE_EDGE;
    @(posedge clk);
    #1;
    chk("modechg_gpio", a_gout[1], 1'b0);
    chk("modechg_cnt", a_cnt[31:16], 16'd0);
    @(posedge clk);
    #1;
    chk("modechg_gpio2", a_gout[1], 1'b0);

    // PULSE, max 2: six edges ten cycles apart on channel 2
    a_max[47:32] = 16'd2;
    a_mode[5:4] = MODE_PULSE;
    repeat (2) @(posedge clk);
    #1;
    dn = 0;
    run = 0;
    pulses = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      a_gin[2] = (cyc < 60) && ((cyc % 10) < 5);
      @(posedge clk);
      #1;
      if (a_done[2]) dn++;
      if (a_gout[2]) begin
        run++;
      end else if (run != 0) begin
        pulses++;
        chk($sformatf("pulse%0d_len", pulses), run, 4);
        chk($sformatf("pulse%0d_cnt0", pulses), a_cnt[47:32], 16'd0);
        run = 0;
      end
    end
    chk("pulse_done_count", dn, 3);
    chk("pulse_count", pulses, 3);

    // Asynchronous reset in the middle of a pulse
    run = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a_gin[2] = (cyc < 12) && ((cyc % 6) < 3);
      @(posedge clk);
      #1;
      if (a_gout[2]) begin
        run = 1;
        break;
      end
    end
    chk("rst_pulse_seen", run, 1);
    chk("rst_pulse_cnt", a_cnt[47:32], 16'd2);
    a_gin[2] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gpio", a_gout, 4'h0);
    chk("arst_done", a_done, 4'h0);
    chk("arst_cnt", a_cnt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rel%0d_gpio", c), a_gout, 4'h0);
      chk($sformatf("rel%0d_done", c), a_done, 4'h0);
      chk($sformatf("rel%0d_cnt", c), a_cnt, 64'h0);
    end

    // Saturation with max 0 beside a concurrently firing PULSE channel
    b_mode = {MODE_PULSE, MODE_EDGE};
    b_max = {4'd3, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    dn = 0;
    bad = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      b_gin = ((cyc < 80) && ((cyc % 4) < 2)) ? 2'b11 : 2'b00;
      @(posedge clk);
      #1;
      if (b_done[1]) dn++;
      if (b_done[0] || b_gout[0]) bad++;
    end
    chk("sat_cnt", b_cnt[3:0], 4'd15);
    chk("sat_never_fires", bad, 0);
    chk("iso_pulse_dones", dn, 5);
    chk("iso_rearm_cnt", b_cnt[7:4], 4'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
